red_pitaya_dacbuf_loader: RTL and testbench
===========================================

# red_pitaya_dacbuf_loader

Streaming loader that sits directly upstream of the ASG channel DAC buffers. It accepts 64-bit sample words (four 16-bit samples) from a valid/ready source, such as the DMA engine. It writes those words into the per-channel dual-port buffers through the dacbuf write port, and uses each channel's two half-buffer ready flags as ping-pong credits so the generators replay continuously without starving.

## Interface
Parameters:
- AW, 12, buffer word address width; half size = 2**(AW-1) = 2048 words (8k samples)
- CW, 32, width of accepted-word counter

Ports:
- dacbuf_clk_i  in  1  clock; same clock as the buffer write side
- dacbuf_rst_i  in  1  synchronous, active-high reset
- ctrl_enable_i  in  1  1 = stream; 0 = abort and idle
- ctrl_chan_i  in  2  channel mask: [0] ch A, [1] ch B; sampled on leaving IDLE
- ctrl_clr_i  in  1  single-cycle pulse; clears stat_underrun_o
- s_data_i  in  64  source word
- s_valid_i  in  1  source word valid
- s_ready_o  out  1  loader accepts word this cycle
- dacbuf_ready_a_i  in  2  ch A half free flags: [0] words 0-2047, [1] words 2048-4095
- dacbuf_ready_b_i  in  2  ch B half free flags
- dacbuf_select_o  out  2  one-hot channel select, [0]=A, [1]=B
- dacbuf_waddr_o  out  AW  write word address
- dacbuf_wdata_o  out  64  write data
- dacbuf_valid_o  out  1  write strobe
- stat_busy_o  out  1  state != IDLE
- stat_underrun_o  out  1  sticky starvation flag
- stat_words_o  out  CW  accepted words, wraps modulo 2**CW

## Operation
- States: IDLE, WAIT_HALF, FILL, DONE_HALF.
- IDLE:
  - Latch mask and clear per-(channel,half) `filled` bits and `armed` bits.
  - Target = (lowest enabled channel, half 0).
  - Leave IDLE for WAIT_HALF when ctrl_enable_i=1 and mask != 00.
  - Mask 00 stays in IDLE.
- WAIT_HALF: go to FILL when the target half is writable (ready flag = 1 and filled = 0).
- FILL:
  - s_ready_o=1.
  - Each accepted word (s_valid_i & s_ready_o) writes {half, offset} and increments the 11-bit offset.
  - Acceptance of the word at offset 2047 goes to DONE_HALF.
- DONE_HALF (one cycle):
  - Set filled[target] and armed[channel].
  - Advance the target, then return to WAIT_HALF.
  - Mask 01 or 10: toggle the half only.
  - Mask 11 order: (A,0) → (B,0) → (A,1) → (B,1) → (A,0) …
- The filled[c][h] bit clears whenever ready[c][h] is sampled 0, meaning the consumer has taken the half.
- Underrun: set stat_underrun_o when, for any enabled and armed channel, both ready bits are 1 and both filled bits are 0. It is sticky until ctrl_clr_i or reset; if set and clear coincide, set wins.
- ctrl_enable_i=0 in any state: next state is IDLE.
  - s_ready_o drops the same cycle because it is combinational from state and enable.
  - An already-accepted word is still written.
  - The offset resets. A partially filled half is not marked filled.
- A mask change while not in IDLE is ignored.

## Timing
- Write port is registered: a word accepted in cycle n gives dacbuf_valid_o=1 in cycle n+1, with its address, data and select.
- dacbuf_valid_o=0 whenever no word was accepted the previous cycle. dacbuf_select_o holds the last value while idle.
- s_ready_o = (state==FILL) & ctrl_enable_i & !dacbuf_rst_i.
  - No word is accepted in WAIT_HALF or DONE_HALF.
  - The minimum gap between halves is 2 cycles (DONE_HALF, WAIT_HALF).
- stat_words_o updates in cycle n+1.
- Ready flags are used as sampled in the current cycle; they are already synchronous to dacbuf_clk_i.
- Reset values: state IDLE, s_ready_o 0, dacbuf_valid_o 0, dacbuf_select_o 00, dacbuf_waddr_o 0, dacbuf_wdata_o 0, stat_busy_o 0, stat_underrun_o 0, stat_words_o 0; all filled and armed bits are 0.
- Reset mid-FILL: all outputs take their reset values the next cycle, and the pending registered write is dropped.

## Structure
- A shared package, red_pitaya_dacbuf_pkg, holds:
  - the state enum;
  - AW_DEF=12;
  - HALF_WORDS=2048;
  - the channel index constants CH_A=0 and CH_B=1.
- Single module; no sub-module is required.
- The filled/armed bookkeeping is a 2×2 register array inside the loader.

## Test plan
- Mask 01, all ready flags 1, continuous valid data 0,1,2…:
  - 2048 writes to ch A at addresses 0–2047, then DONE_HALF.
  - Half 1 writes start at address 2048 with data 2048.
  - stat_words_o=4096 after 4096 accepts.
- Mask 11:
  - Write sequence: A h0, B h0, A h1, B h1; select 01, 10, 01, 10.
  - Hold ready_a_i[0]=1 (never dropped): the loader stalls in WAIT_HALF before the second A h0.
  - Pulse ready_a_i[0] to 0 for one cycle: filling resumes.
- Backpressure: s_valid_i toggling 1010…: only accepted words are written, each exactly one cycle after acceptance, and offsets have no gaps.
- Disable at offset 1000:
  - The word accepted in the disable cycle is still written.
  - The loader goes to IDLE.
  - Re-enable restarts at (A,0) offset 0.
- Underrun: after A h0 and A h1 are filled, drive ready_a_i 0 then 11 while the source is idle → stat_underrun_o=1. A ctrl_clr_i pulse clears it the next cycle.
- Synchronous reset asserted mid-FILL: the next cycle shows all outputs at their reset values and no dacbuf_valid_o for the pending word.

Source files
------------

// File: rtl/red_pitaya_dacbuf_pkg.sv
// -----------------------------------------------------------------------------
// red_pitaya_dacbuf_pkg
// Shared definitions for the ASG DAC buffer streaming loader.
//   - state_t     : loader FSM states
//   - AW_DEF      : default buffer word address width (4096 words, 2 halves)
//   - HALF_WORDS  : words per half buffer at the default width
//   - CH_A / CH_B : channel index constants (index into masks and flag arrays)
//   - chan_onehot : converts a channel index into the one-hot write select
// -----------------------------------------------------------------------------
package red_pitaya_dacbuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HALF = 2'd1,
        ST_FILL      = 2'd2,
        ST_DONE_HALF = 2'd3
    } state_t;

    localparam int   AW_DEF     = 12;
    localparam int   HALF_WORDS = 2048;
    localparam logic CH_A       = 1'b0;
    localparam logic CH_B       = 1'b1;

    // One-hot write select for a channel index: [0]=A, [1]=B.
    function automatic logic [1:0] chan_onehot(input logic ch);
        logic [1:0] sel;
        case (ch)
            CH_A:    sel = 2'b01;
            CH_B:    sel = 2'b10;
            default: sel = 2'b00;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/red_pitaya_dacbuf_loader.sv
// -----------------------------------------------------------------------------
// red_pitaya_dacbuf_loader
// Streams 64-bit sample words from a valid/ready source into the per-channel
// ASG DAC buffers. Each channel buffer is split in two halves; the consumer's
// per-half "ready" (free) flags act as ping-pong credits. A half is filled
// completely (HALF_WORDS words) before the loader moves on to the next target.
//
// Ports:
//   dacbuf_clk_i / dacbuf_rst_i : clock, synchronous active-high reset
//   ctrl_enable_i               : 1 = stream, 0 = abort and return to idle
//   ctrl_chan_i                 : channel mask [0]=A [1]=B, latched in idle
//   ctrl_clr_i                  : clears the sticky underrun flag
//   s_data_i/s_valid_i/s_ready_o: source word stream
//   dacbuf_ready_a_i/_b_i       : per-half free flags of channels A and B
//   dacbuf_select_o/_waddr_o/_wdata_o/_valid_o : registered buffer write port
//   stat_busy_o                 : loader not idle
//   stat_underrun_o             : sticky starvation flag
//   stat_words_o                : accepted word counter (wraps)
// -----------------------------------------------------------------------------
module red_pitaya_dacbuf_loader
    import red_pitaya_dacbuf_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int CW = 32
) (
    input  logic          dacbuf_clk_i,
    input  logic          dacbuf_rst_i,
    input  logic          ctrl_enable_i,
    input  logic [1:0]    ctrl_chan_i,
    input  logic          ctrl_clr_i,
    input  logic [63:0]   s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [1:0]    dacbuf_ready_a_i,
    input  logic [1:0]    dacbuf_ready_b_i,
    output logic [1:0]    dacbuf_select_o,
    output logic [AW-1:0] dacbuf_waddr_o,
    output logic [63:0]   dacbuf_wdata_o,
    output logic          dacbuf_valid_o,
    output logic          stat_busy_o,
    output logic          stat_underrun_o,
    output logic [CW-1:0] stat_words_o
);

    // Offset within a half buffer.
    localparam int             OW       = AW - 1;
    localparam logic [OW-1:0]  OFF_LAST = {OW{1'b1}};
    localparam logic [OW-1:0]  OFF_ONE  = {{(OW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [1:0]      r_mask;
    logic            r_chan;       // target channel index
    logic            r_half;       // target half
    logic [OW-1:0]   r_offset;
    logic [1:0][1:0] r_filled;     // [channel][half]: half written, not yet consumed
    logic [1:0]      r_armed;      // channel has had at least one half delivered

    logic [1:0]      r_select;
    logic [AW-1:0]   r_waddr;
    logic [63:0]     r_wdata;
    logic            r_wvalid;
    logic            r_underrun;
    logic [CW-1:0]   r_words;

    logic [1:0][1:0] w_ready;      // [channel][half]
    logic            w_accept;
    logic            w_target_free;
    logic [1:0]      w_starve;
    logic            w_underrun_set;

    assign w_ready       = {dacbuf_ready_b_i, dacbuf_ready_a_i};
    assign s_ready_o     = (r_state == ST_FILL) & ctrl_enable_i & ~dacbuf_rst_i;
    assign w_accept      = s_valid_i & s_ready_o;
    assign w_target_free = w_ready[r_chan][r_half] & ~r_filled[r_chan][r_half];

    // Starvation: an active channel has both halves free and nothing queued.
    always_comb begin
        w_starve = 2'b00;
        for (int c = 0; c < 2; c++) begin
            w_starve[c] = r_mask[c] & r_armed[c] & (&w_ready[c]) & ~(|r_filled[c]);
        end
        w_underrun_set = (r_state != ST_IDLE) & (|w_starve);
    end

    // Loader FSM with target selection and filled/armed bookkeeping.
    always_ff @(posedge dacbuf_clk_i) begin
        if (dacbuf_rst_i) begin
            r_state  <= ST_IDLE;
            r_mask   <= 2'b00;
            r_chan   <= CH_A;
            r_half   <= 1'b0;
            r_offset <= {OW{1'b0}};
            r_filled <= 4'b0000;
            r_armed  <= 2'b00;
        end else begin
            // A half the consumer reports busy has been taken; forget it was filled.
            r_filled <= r_filled & w_ready;
            case (r_state)
                ST_IDLE: begin
                    r_mask   <= ctrl_chan_i;
                    r_chan   <= ctrl_chan_i[0] ? CH_A : CH_B;
                    r_half   <= 1'b0;
                    r_offset <= {OW{1'b0}};
                    r_filled <= 4'b0000;
                    r_armed  <= 2'b00;
                    if (ctrl_chan_i != 2'b00) begin
                        r_state <= ST_WAIT_HALF;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_HALF: begin
                    if (w_target_free) begin
                        r_state <= ST_FILL;
                    end else begin
                        r_state <= ST_WAIT_HALF;
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_offset <= r_offset + OFF_ONE;
                        if (r_offset == OFF_LAST) begin
                            r_state <= ST_DONE_HALF;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end else begin
                        r_state <= ST_FILL;
                    end
                end
                ST_DONE_HALF: begin
                    // Marking the completed half overrides the consumer clear above.
                    r_filled[r_chan][r_half] <= 1'b1;
                    r_armed[r_chan]          <= 1'b1;
                    if (r_mask == 2'b11) begin
                        // Interleave channels: (A,h) -> (B,h) -> (A,~h)
                        if (r_chan == CH_A) begin
                            r_chan <= CH_B;
                        end else begin
                            r_chan <= CH_A;
                            r_half <= ~r_half;
                        end
                    end else begin
                        r_half <= ~r_half;
                    end
                    r_state <= ST_WAIT_HALF;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            // Disable aborts from any state; a partial half is discarded.
            if (!ctrl_enable_i) begin
                r_state  <= ST_IDLE;
                r_offset <= {OW{1'b0}};
            end
        end
    end

    // Registered buffer write port: an accepted word is written one cycle later.
    always_ff @(posedge dacbuf_clk_i) begin
        if (dacbuf_rst_i) begin
            r_wvalid <= 1'b0;
            r_select <= 2'b00;
            r_waddr  <= {AW{1'b0}};
            r_wdata  <= 64'h0;
        end else begin
            r_wvalid <= w_accept;
            if (w_accept) begin
                r_select <= chan_onehot(r_chan);
                r_waddr  <= {r_half, r_offset};
                r_wdata  <= s_data_i;
            end else begin
                r_select <= r_select;
                r_waddr  <= r_waddr;
                r_wdata  <= r_wdata;
            end
        end
    end

    // Status: accepted-word counter and sticky underrun (set beats clear).
    always_ff @(posedge dacbuf_clk_i) begin
        if (dacbuf_rst_i) begin
            r_words    <= {CW{1'b0}};
            r_underrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_words <= r_words + CNT_ONE;
            end else begin
                r_words <= r_words;
            end
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (ctrl_clr_i) begin
                r_underrun <= 1'b0;
            end else begin
                r_underrun <= r_underrun;
            end
        end
    end

    assign dacbuf_select_o = r_select;
    assign dacbuf_waddr_o  = r_waddr;
    assign dacbuf_wdata_o  = r_wdata;
    assign dacbuf_valid_o  = r_wvalid;
    assign stat_busy_o     = (r_state != ST_IDLE);
    assign stat_underrun_o = r_underrun;
    assign stat_words_o    = r_words;

endmodule

// File: tb/tb_red_pitaya_dacbuf_loader.sv
// -----------------------------------------------------------------------------
// tb_red_pitaya_dacbuf_loader
// Directed testbench for red_pitaya_dacbuf_loader. Each accepted word is
// expected on the write port one cycle later at the address of a hand-written
// target sequence; cycle counts, stalls, underrun and reset are checked directly.
// -----------------------------------------------------------------------------
module tb_red_pitaya_dacbuf_loader;
    import red_pitaya_dacbuf_pkg::*;

    localparam int AW = 12;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    chan;
    logic          clr;
    logic [63:0]   s_data;
    logic          s_valid;
    logic          s_ready;
    logic [1:0]    rdy_a;
    logic [1:0]    rdy_b;
    logic [1:0]    sel;
    logic [AW-1:0] waddr;
    logic [63:0]   wdata;
    logic          wvalid;
    logic          busy;
    logic          underrun;
    logic [CW-1:0] words;

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_acc;
    int            base;
    int            cyc;
    logic [CW-1:0] n_words;
    logic [63:0]   d;
    logic [1:0]    seq_sel [4];
    logic          seq_half [4];
    int            seg;
    logic [10:0]   exp_off;

    always #5 clk = ~clk;

    red_pitaya_dacbuf_loader #(.AW(AW), .CW(CW)) dut (
        .dacbuf_clk_i     (clk),
        .dacbuf_rst_i     (rst),
        .ctrl_enable_i    (en),
        .ctrl_chan_i      (chan),
        .ctrl_clr_i       (clr),
        .s_data_i         (s_data),
        .s_valid_i        (s_valid),
        .s_ready_o        (s_ready),
        .dacbuf_ready_a_i (rdy_a),
        .dacbuf_ready_b_i (rdy_b),
        .dacbuf_select_o  (sel),
        .dacbuf_waddr_o   (waddr),
        .dacbuf_wdata_o   (wdata),
        .dacbuf_valid_o   (wvalid),
        .stat_busy_o      (busy),
        .stat_underrun_o  (underrun),
        .stat_words_o     (words)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected fill order: one entry per half buffer.
    task automatic start_stream(input logic [1:0] mask);
        chan    = mask;
        seg     = 0;
        exp_off = 11'd0;
        if (mask == 2'b11) begin
            seq_sel[0] = 2'b01; seq_half[0] = 1'b0;
            seq_sel[1] = 2'b10; seq_half[1] = 1'b0;
            seq_sel[2] = 2'b01; seq_half[2] = 1'b1;
            seq_sel[3] = 2'b10; seq_half[3] = 1'b1;
        end else begin
            seq_sel[0] = mask;  seq_half[0] = 1'b0;
            seq_sel[1] = mask;  seq_half[1] = 1'b1;
            seq_sel[2] = mask;  seq_half[2] = 1'b0;
            seq_sel[3] = mask;  seq_half[3] = 1'b1;
        end
    endtask

    // One clock: a handshake before the edge must show up as a write after it.
    task automatic tick();
        logic        acc;
        logic [63:0] acc_data;
        #1;
        acc      = s_valid & s_ready;
        acc_data = s_data;
        @(posedge clk);
        #1;
        if (acc) begin
            n_acc++;
            n_words++;
            check_eq("wr_valid", {63'd0, wvalid}, 64'd1);
            check_eq("wr_addr", {52'd0, waddr}, {52'd0, seq_half[seg], exp_off});
            check_eq("wr_data", wdata, acc_data);
            check_eq("wr_sel", {62'd0, sel}, {62'd0, seq_sel[seg]});
            exp_off++;
            if (exp_off == 11'd0) seg = (seg + 1) % 4;
            d++;
            s_data = d;
        end else begin
            check_eq("wr_idle", {63'd0, wvalid}, 64'd0);
        end
        check_eq("words", {32'd0, words}, {32'd0, n_words});
    endtask

    task automatic run_until(input string tag, input int target, input int bound, output int cycles);
        cycles = 0;
        while (n_acc < target && cycles < bound) begin
            tick();
            cycles++;
        end
        check_eq(tag, 64'(n_acc), 64'(target));
    endtask

    task automatic stop_stream();
        en      = 1'b0;
        s_valid = 1'b0;
        tick();
        tick();
        check_eq("idle_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; chan = 2'b00; clr = 1'b0;
        s_valid = 1'b0; d = 64'd0; s_data = 64'd0;
        rdy_a = 2'b11; rdy_b = 2'b11;
        n_acc = 0; n_words = '0;
        start_stream(2'b01);
        repeat (3) tick();
        check_eq("rst_ready", {63'd0, s_ready}, 64'd0);
        check_eq("rst_sel", {62'd0, sel}, 64'd0);
        check_eq("rst_waddr", {52'd0, waddr}, 64'd0);
        check_eq("rst_wdata", wdata, 64'd0);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_underrun", {63'd0, underrun}, 64'd0);
        rst = 1'b0;
        tick();

        // Mask A only, continuous data 0,1,2...: two halves back to back.
        start_stream(2'b01);
        d = 64'd0; s_data = 64'd0; s_valid = 1'b1; en = 1'b1;
        run_until("m01_4096", 4096, 5000, cyc);
        check_eq("m01_cycles", 64'(cyc), 64'(2 * HALF_WORDS + 4));
        check_eq("m01_words", {32'd0, words}, 64'd4096);
        repeat (10) tick();
        check_eq("m01_stall", 64'(n_acc), 64'd4096);
        check_eq("m01_stall_rdy", {63'd0, s_ready}, 64'd0);
        check_eq("m01_busy", {63'd0, busy}, 64'd1);
        check_eq("m01_underrun", {63'd0, underrun}, 64'd0);
        stop_stream();

        // Both channels: A0, B0, A1, B1, then stall until A0 is consumed.
        start_stream(2'b11);
        base = n_acc; d = 64'd0; s_data = 64'd0; s_valid = 1'b1; en = 1'b1;
        run_until("m11_4halves", base + 8192, 8300, cyc);
        check_eq("m11_cycles", 64'(cyc), 64'd8200);
        repeat (10) tick();
        check_eq("m11_stall", 64'(n_acc), 64'(base + 8192));
        check_eq("m11_stall_rdy", {63'd0, s_ready}, 64'd0);
        rdy_a = 2'b10;
        tick();
        rdy_a = 2'b11;
        run_until("m11_resume", base + 8192 + 16, 40, cyc);
        check_eq("m11_underrun", {63'd0, underrun}, 64'd0);
        stop_stream();

        // Backpressure: valid toggles, offsets must stay gap-free.
        start_stream(2'b01);
        base = n_acc; en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            s_valid = (i % 2 == 1);
            tick();
        end
        check_eq("bp_accepts", 64'(n_acc - base), 64'd19);
        stop_stream();

        // Disable at offset 1000, then restart at (A,0) offset 0.
        start_stream(2'b01);
        base = n_acc; s_valid = 1'b1; en = 1'b1;
        run_until("dis_1000", base + 1000, 1100, cyc);
        en = 1'b0;
        #1;
        check_eq("dis_ready", {63'd0, s_ready}, 64'd0);
        check_eq("dis_last_valid", {63'd0, wvalid}, 64'd1);
        check_eq("dis_last_addr", {52'd0, waddr}, 64'd999);
        tick();
        check_eq("dis_busy", {63'd0, busy}, 64'd0);
        seg = 0; exp_off = 11'd0; en = 1'b1;
        run_until("dis_restart", base + 1010, 20, cyc);
        check_eq("dis_restart_cyc", 64'(cyc), 64'd12);
        stop_stream();

        // Underrun: both A halves filled, consumer takes both, source idle.
        start_stream(2'b01);
        base = n_acc; s_valid = 1'b1; en = 1'b1;
        run_until("ur_fill", base + 4096, 4200, cyc);
        s_valid = 1'b0;
        repeat (3) tick();
        check_eq("ur_none", {63'd0, underrun}, 64'd0);
        rdy_a = 2'b00;
        tick();
        check_eq("ur_taken", {63'd0, underrun}, 64'd0);
        rdy_a = 2'b11;
        tick();
        check_eq("ur_set", {63'd0, underrun}, 64'd1);
        rdy_a = 2'b01;
        tick();
        check_eq("ur_sticky", {63'd0, underrun}, 64'd1);
        rdy_a = 2'b11; clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("ur_set_wins", {63'd0, underrun}, 64'd1);
        rdy_a = 2'b01; clr = 1'b1;
        tick();
        clr = 1'b0;
        check_eq("ur_clr", {63'd0, underrun}, 64'd0);
        tick();
        check_eq("ur_stays_clr", {63'd0, underrun}, 64'd0);
        stop_stream();
        rdy_a = 2'b11;

        // Synchronous reset in the middle of a fill.
        start_stream(2'b01);
        base = n_acc; s_valid = 1'b1; en = 1'b1;
        run_until("rst_fill", base + 10, 20, cyc);
        rst = 1'b1;
        #1;
        check_eq("rstf_ready", {63'd0, s_ready}, 64'd0);
        n_words = '0;
        tick();
        check_eq("rstf_valid", {63'd0, wvalid}, 64'd0);
        check_eq("rstf_sel", {62'd0, sel}, 64'd0);
        check_eq("rstf_waddr", {52'd0, waddr}, 64'd0);
        check_eq("rstf_wdata", wdata, 64'd0);
        check_eq("rstf_busy", {63'd0, busy}, 64'd0);
        check_eq("rstf_underrun", {63'd0, underrun}, 64'd0);
        rst = 1'b0; en = 1'b0; s_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
